// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
package uart_pkg;

    // Default number of clk cycles per serial bit period.
    localparam int UART_CLKS_PER_BIT = 16;

    // Frame sequencing states shared by the UART receive and transmit paths.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period cycle counter: restartable, flags the bit centre and the bit end.
module baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic mid_tick,
    output logic full_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    // Free-running modulo-CLKS_PER_BIT counter, forced to zero by restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (restart || cnt == CW'(CLKS_PER_BIT - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // mid_tick marks the last cycle of a half period, full_tick of a full period.
    assign mid_tick  = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronizes rx_in, deserializes LSB-first frames and hands
// them to a consumer over a valid/ready register with overrun/frame-error pulses.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int BC_W = $clog2(WIDTH + 1);

    uart_state_e      state;
    logic             sync1;
    logic             rx_s;
    logic             rx_d;
    logic             fall;
    logic [BC_W-1:0]  bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             restart;
    logic             mid_tick;
    logic             full_tick;

    // Two-flop synchronizer plus one delay stage for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
            rx_d  <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

    // Counter held at zero in IDLE; re-phased at the start-bit centre so that
    // every later full_tick lands on a bit centre.
    assign restart = (state == IDLE) || (state == START && mid_tick);

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .mid_tick  (mid_tick),
        .full_tick (full_tick)
    );

    // Frame FSM with registered payload, handshake and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // Consumer handshake; a completing frame below may re-set valid.
            if (data_valid && data_ready)
                data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                START: begin
                    // Line back high at the start-bit centre: treat as a glitch.
                    if (mid_tick)
                        state <= rx_s ? IDLE : DATA;
                end
                DATA: begin
                    if (full_tick) begin
                        shreg   <= {rx_s, shreg[WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BC_W'(WIDTH - 1))
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (full_tick) begin
                        state <= IDLE;
                        if (!rx_s)
                            frame_err <= 1'b1;
                        else if (!data_valid || data_ready) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                        end else
                            overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed + randomized bench for uart_rx_ctrl with a frame-level reference model.
module tb_uart_rx_ctrl;

    localparam int W   = 8;
    localparam int CPB = 16;

    logic         clk;
    logic         reset;
    logic         rx_in;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int fe_hi = 0;
    int ov_hi = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    logic dv_q = 1'b0;

    // Reference model state: what the consumer register should hold.
    logic [W-1:0] exp_data;
    logic         exp_valid;

    uart_rx_ctrl #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse/edge monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err) fe_hi++;
        if (overrun)   ov_hi++;
        if (data_valid && !dv_q) rise_cyc = cyc;
        dv_q = data_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame starting at the current negedge: start, LSB-first data, stop, idle gap.
    task automatic send_frame(input logic [W-1:0] d, input logic stop_v, input int gap);
        rx_in = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < W; i++) begin
            rx_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop_v;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Model a frame reaching its stop sample with data_ready low throughout.
    task automatic model_frame(input logic [W-1:0] d, input logic stop_v,
                               output int exp_fe, output int exp_ov);
        exp_fe = 0;
        exp_ov = 0;
        if (!stop_v) exp_fe = 1;
        else if (!exp_valid) begin
            exp_data  = d;
            exp_valid = 1'b1;
        end else exp_ov = 1;
    endtask

    task automatic consume();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int k = 0;
        while (busy !== lvl && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic check_state(input string tag, input int fe0, input int ov0,
                               input int efe, input int eov);
        chk({tag, "_data"},  32'(data_out),   32'(exp_data));
        chk({tag, "_valid"}, 32'(data_valid), 32'(exp_valid));
        chk({tag, "_ferr"},  32'(fe_hi - fe0), 32'(efe));
        chk({tag, "_ovr"},   32'(ov_hi - ov0), 32'(eov));
    endtask

    initial begin
        int fe0, ov0, efe, eov, dly;
        logic [W-1:0] d;
        logic sv;

        reset = 1'b0;
        rx_in = 1'b1;
        data_ready = 1'b0;
        exp_data = '0;
        exp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_out",   32'(data_out),   32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_frame_err",  32'(frame_err),  32'h0);
        chk("rst_overrun",    32'(overrun),    32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5 good frame, latency window, hold until consumed.
        fe0 = fe_hi; ov0 = ov_hi;
        send_frame(8'hA5, 1'b1, 20);
        model_frame(8'hA5, 1'b1, efe, eov);
        check_state("a5", fe0, ov0, efe, eov);
        dly = rise_cyc - fall_cyc;
        chk("a5_latency_window", 32'(dly >= 152 && dly <= 156), 32'h1);
        repeat (50) @(negedge clk);
        chk("a5_hold_valid", 32'(data_valid), 32'h1);
        chk("a5_hold_data",  32'(data_out),   32'hA5);
        consume();
        chk("a5_consumed", 32'(data_valid), 32'h0);
        chk("a5_busy_idle", 32'(busy), 32'h0);

        // Short low glitch on an idle line is rejected silently.
        fe0 = fe_hi; ov0 = ov_hi;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'h0);
        check_state("glitch", fe0, ov0, 0, 0);

        // Stop bit low: single-cycle frame_err, payload untouched.
        fe0 = fe_hi; ov0 = ov_hi;
        send_frame(8'h3C, 1'b0, 20);
        model_frame(8'h3C, 1'b0, efe, eov);
        check_state("ferr", fe0, ov0, efe, eov);

        // Back-to-back 0x11, 0x22 with no consumer: second frame overruns.
        fe0 = fe_hi; ov0 = ov_hi;
        send_frame(8'h11, 1'b1, 0);
        model_frame(8'h11, 1'b1, efe, eov);
        send_frame(8'h22, 1'b1, 20);
        model_frame(8'h22, 1'b1, efe, eov);
        check_state("b2b_ovr", fe0, ov0, 0, eov);
        consume();

        // Same pair, ready pulsed on the second completion edge (START entry + half + 9 bits).
        fe0 = fe_hi; ov0 = ov_hi;
        fork
            begin
                send_frame(8'h11, 1'b1, 0);
                send_frame(8'h22, 1'b1, 20);
            end
            begin
                wait_busy(1'b1, "hs_f1_start");
                wait_busy(1'b0, "hs_f1_end");
                wait_busy(1'b1, "hs_f2_start");
                repeat (CPB / 2 + (W + 1) * CPB - 1) @(negedge clk);
                data_ready = 1'b1;
                @(negedge clk);
                data_ready = 1'b0;
            end
        join
        exp_data = 8'h22;
        exp_valid = 1'b1;
        check_state("b2b_hs", fe0, ov0, 0, 0);
        consume();

        // Reset during bit 3 of 0xFF, then a clean 0x5A.
        fe0 = fe_hi; ov0 = ov_hi;
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        exp_data = '0;
        exp_valid = 1'b0;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_data", 32'(data_out), 32'h0);
        reset = 1'b1;
        repeat (6 * CPB) @(negedge clk);
        send_frame(8'h5A, 1'b1, 20);
        model_frame(8'h5A, 1'b1, efe, eov);
        check_state("midrst_5a", fe0, ov0, efe, eov);

        // Randomized frames, stop-bit errors and consumer behaviour.
        for (int n = 0; n < 12; n++) begin
            d = W'($urandom_range(0, 255));
            sv = ($urandom_range(0, 4) != 0);
            fe0 = fe_hi; ov0 = ov_hi;
            send_frame(d, sv, 20);
            model_frame(d, sv, efe, eov);
            check_state($sformatf("rnd%0d", n), fe0, ov0, efe, eov);
            if ($urandom_range(0, 1) == 1) begin
                consume();
                chk($sformatf("rnd%0d_consume", n), 32'(data_valid), 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
